// File: rtl/freq_pkg.sv
// Shared definitions for the frequency meter: FSM states and default sizing.
package freq_pkg;

  // Measurement controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2
  } state_t;

  localparam int DEF_CNT_WIDTH   = 24;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchronizer followed by a rising-edge detector.
// The pulse output is combinational from the last synchronizer stage and its
// registered copy, so it is high for exactly one clk cycle per input rise.
// SYNC_STAGES must be at least 2.
module edge_sync
  import freq_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   last_q;

  // Shift the asynchronous input through the synchronizer and keep a delayed copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync   <= '0;
      last_q <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], async_in};
      last_q <= sync[SYNC_STAGES-1];
    end
  end

  assign pulse = sync[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/freq_meter.sv
// Gated frequency meter: counts synchronized sig_in rising edges between
// consecutive gate_in rising edges and reports each completed window.
//
// Handshake: valid is a one-cycle strobe with no back-pressure; count and
// overflow change only on a valid strobe and hold their value otherwise.
module freq_meter
  import freq_pkg::*;
#(
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 gate_in,
  input  logic                 sig_in,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 valid,
  output logic                 overflow,
  output logic                 busy
);

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] acc, acc_nxt, acc_inc, count_nxt;
  logic                 ovf, ovf_nxt, ovf_inc;
  logic                 overflow_nxt, valid_nxt;
  logic                 gate_rise, sig_rise;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_gate_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (gate_in),
    .pulse    (gate_rise)
  );

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sig_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (sig_in),
    .pulse    (sig_rise)
  );

  // Saturating accumulator step: value after counting this cycle's sig edge.
  always_comb begin
    acc_inc = acc;
    ovf_inc = ovf;
    if (sig_rise) begin
      if (&acc) ovf_inc = 1'b1;
      else      acc_inc = acc + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Next-state and datapath decisions; en low always wins and drops the window.
  always_comb begin
    state_nxt    = state;
    acc_nxt      = acc;
    ovf_nxt      = ovf;
    count_nxt    = count;
    overflow_nxt = overflow;
    valid_nxt    = 1'b0;
    case (state)
      IDLE: begin
        acc_nxt = '0;
        ovf_nxt = 1'b0;
        if (en) state_nxt = ARM;
      end
      ARM: begin
        if (!en) begin
          state_nxt = IDLE;
          acc_nxt   = '0;
          ovf_nxt   = 1'b0;
        end else if (gate_rise) begin
          // Opening edge: a coincident sig edge is deliberately not counted.
          state_nxt = COUNT;
          acc_nxt   = '0;
          ovf_nxt   = 1'b0;
        end
      end
      COUNT: begin
        if (!en) begin
          state_nxt = IDLE;
          acc_nxt   = '0;
          ovf_nxt   = 1'b0;
        end else if (gate_rise) begin
          // Closing edge: a coincident sig edge belongs to the closing window.
          count_nxt    = acc_inc;
          overflow_nxt = ovf_inc;
          valid_nxt    = 1'b1;
          acc_nxt      = '0;
          ovf_nxt      = 1'b0;
        end else begin
          acc_nxt = acc_inc;
          ovf_nxt = ovf_inc;
        end
      end
      default: begin
        state_nxt = IDLE;
        acc_nxt   = '0;
        ovf_nxt   = 1'b0;
      end
    endcase
  end

  // State, accumulator and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      ovf      <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
      valid    <= 1'b0;
    end else begin
      state    <= state_nxt;
      acc      <= acc_nxt;
      ovf      <= ovf_nxt;
      count    <= count_nxt;
      overflow <= overflow_nxt;
      valid    <= valid_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: a 24-bit instance and a 4-bit instance share
// the same stimulus; a negedge monitor records every valid strobe.
module tb_freq_meter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        gate_in = 1'b0;
  logic        sig_in = 1'b0;
  logic [23:0] count;
  logic        valid, overflow, busy;
  logic [3:0]  s_count;
  logic        s_valid, s_overflow, s_busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int gate_cyc = 0;

  logic [23:0] cnt_q[$];
  logic        ovf_q[$];
  int          lat_q[$];
  logic [3:0]  s_cnt_q[$];
  logic        s_ovf_q[$];

  freq_meter dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .gate_in  (gate_in),
    .sig_in   (sig_in),
    .count    (count),
    .valid    (valid),
    .overflow (overflow),
    .busy     (busy)
  );

  freq_meter #(.CNT_WIDTH(4)) dut_s (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .gate_in  (gate_in),
    .sig_in   (sig_in),
    .count    (s_count),
    .valid    (s_valid),
    .overflow (s_overflow),
    .busy     (s_busy)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor: capture every result strobe and its latency from the last gate rise
  always @(negedge clk) begin
    if (valid) begin
      cnt_q.push_back(count);
      ovf_q.push_back(overflow);
      lat_q.push_back(cyc - gate_cyc);
    end
    if (s_valid) begin
      s_cnt_q.push_back(s_count);
      s_ovf_q.push_back(s_overflow);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    cnt_q.delete();
    ovf_q.delete();
    lat_q.delete();
    s_cnt_q.delete();
    s_ovf_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    gate_in = 1'b0;
    sig_in = 1'b0;
    repeat (3) tick();
    clear_q();
    rst = 1'b0;
    tick();
  endtask

  // One gate period of len cycles starting with a raw gate rise; nsig sig
  // rises of period per, the first at cycle off.
  task automatic window(input int len, input int per, input int nsig, input int off);
    for (int c = 0; c < len; c++) begin
      int p;
      p = c - off;
      gate_in = (c < len / 2);
      sig_in = (p >= 0) && (p / per < nsig) && (p % per < per / 2);
      if (c == 0) gate_cyc = cyc;
      tick();
    end
  endtask

  initial begin
    // reset state
    do_reset();
    check("rst_count", count, 0);
    check("rst_valid", valid, 0);
    check("rst_ovf", overflow, 0);
    check("rst_busy", busy, 0);

    // back-to-back 1000-cycle windows, sig period 10
    en = 1'b1;
    tick();
    check("arm_busy", busy, 1);
    window(1000, 10, 100, 5);
    check("first_edge_no_valid", cnt_q.size(), 0);
    window(1000, 10, 100, 5);
    window(1000, 10, 100, 5);
    window(1000, 10, 0, 5);
    check("p1000_nvalid", cnt_q.size(), 3);
    for (int i = 0; i < cnt_q.size(); i++) begin
      check("p1000_count", cnt_q[i], 100);
      check("p1000_ovf", ovf_q[i], 0);
      check("p1000_latency", lat_q[i], 3);
    end

    // saturation on the 4-bit instance: 20 edges then 5
    do_reset();
    en = 1'b1;
    tick();
    window(100, 4, 20, 5);
    window(100, 4, 20, 5);
    window(100, 4, 5, 5);
    window(100, 4, 0, 5);
    check("sat_nvalid", s_cnt_q.size(), 3);
    if (s_cnt_q.size() == 3) begin
      check("sat_count", s_cnt_q[1], 15);
      check("sat_ovf", s_ovf_q[1], 1);
      check("after_sat_count", s_cnt_q[2], 5);
      check("after_sat_ovf", s_ovf_q[2], 0);
    end
    if (cnt_q.size() == 3) begin
      check("wide_20_count", cnt_q[1], 20);
      check("wide_20_ovf", ovf_q[1], 0);
      check("wide_5_count", cnt_q[2], 5);
    end

    // en dropped mid-window
    do_reset();
    en = 1'b1;
    tick();
    window(100, 10, 5, 5);
    window(100, 10, 4, 5);
    en = 1'b0;
    tick();
    check("endrop_busy", busy, 0);
    check("endrop_nvalid", cnt_q.size(), 1);
    check("endrop_count_hold", count, 5);
    window(100, 10, 3, 5);
    check("idle_no_valid", cnt_q.size(), 1);
    check("idle_busy", busy, 0);
    en = 1'b1;
    window(100, 10, 7, 5);
    check("rearm_no_early_valid", cnt_q.size(), 1);
    window(100, 10, 0, 5);
    check("rearm_nvalid", cnt_q.size(), 2);
    if (cnt_q.size() == 2) begin
      check("rearm_count", cnt_q[1], 7);
      check("rearm_latency", lat_q[1], 3);
    end

    // coincident sig edge on closing gate edge is counted
    do_reset();
    en = 1'b1;
    tick();
    window(100, 10, 9, 5);
    window(100, 10, 1, 0);
    window(100, 10, 0, 5);
    check("coin_close_nvalid", cnt_q.size(), 2);
    if (cnt_q.size() == 2) begin
      check("coin_close_count", cnt_q[0], 10);
      check("coin_next_count", cnt_q[1], 0);
    end

    // coincident sig edge on opening gate edge (in ARM) is not counted
    do_reset();
    en = 1'b1;
    tick();
    window(100, 10, 3, 0);
    window(100, 10, 0, 5);
    check("coin_open_nvalid", cnt_q.size(), 1);
    if (cnt_q.size() == 1) check("coin_open_count", cnt_q[0], 2);

    // reset pulsed during COUNT
    do_reset();
    en = 1'b1;
    tick();
    window(100, 10, 8, 5);
    window(100, 10, 6, 5);
    for (int i = 0; i < 3; i++) begin
      sig_in = 1'b1;
      repeat (3) tick();
      sig_in = 1'b0;
      repeat (3) tick();
    end
    check("pre_rst_count", count, 8);
    rst = 1'b1;
    #1;
    check("midrst_count", count, 0);
    check("midrst_valid", valid, 0);
    check("midrst_busy", busy, 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    window(1000, 10, 100, 5);
    check("postrst_no_early_valid", cnt_q.size(), 1);
    window(1000, 10, 0, 5);
    check("postrst_nvalid", cnt_q.size(), 2);
    if (cnt_q.size() == 2) begin
      check("postrst_count", cnt_q[1], 100);
      check("postrst_ovf", ovf_q[1], 0);
    end

    // gate static low with sig toggling: no valid
    do_reset();
    en = 1'b1;
    tick();
    window(100, 10, 4, 5);
    window(100, 10, 0, 5);
    check("static_pre_count", count, 4);
    gate_in = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      sig_in = ((c % 10) < 5);
      tick();
    end
    sig_in = 1'b0;
    check("static_nvalid", cnt_q.size(), 1);
    check("static_count", count, 4);
    check("static_busy", busy, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
